// File: rtl/gpr_file_pkg.sv
// Shared CPU definitions for the register bank and its neighbours (the operand
// selector and the control FSM): widths, index/data types and state bit positions.
package gpr_file_pkg;

   localparam int GPR_DATA_W = 16;  // width of one general-purpose register
   localparam int GPR_SEL_W  = 4;   // register-index width, fixed
   localparam int GPR_NREGS  = 16;  // number of registers addressable by GPR_SEL_W

   typedef logic [GPR_SEL_W-1:0]  reg_idx_t;
   typedef logic [GPR_DATA_W-1:0] data_t;

   // One-hot state bit positions shared by the selector and the control FSM.
   localparam int ST_IDLE_BIT   = 0;
   localparam int ST_FETCH_BIT  = 1;
   localparam int ST_DECODE_BIT = 2;
   localparam int ST_OPSEL_BIT  = 3;
   localparam int ST_EXEC_BIT   = 4;
   localparam int ST_MUL_BIT    = 5;
   localparam int ST_WB_BIT     = 6;
   localparam int ST_NUM_STATES = 7;

   // True when an enabled port addresses register idx.
   function automatic logic idx_hit(input logic en, input reg_idx_t sel, input int idx);
      return en && (sel == reg_idx_t'(idx));
   endfunction

endpackage : gpr_file_pkg

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one lock bit per register, set by the control FSM when
// a multi-cycle result is outstanding and cleared by the write that delivers it.
module gpr_scoreboard
   import gpr_file_pkg::*;
#(
   parameter int NREGS = GPR_NREGS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en1,
   input  reg_idx_t         wr_sel1,
   input  logic             wr_en2,
   input  reg_idx_t         wr_sel2,
   input  logic             lock_en,
   input  reg_idx_t         lock_sel,
   input  reg_idx_t         GPR_sel1,
   input  reg_idx_t         GPR_sel2,
   output logic             busy1,
   output logic             busy2,
   output logic [NREGS-1:0] lock_vec
);

   logic [NREGS-1:0] lock_q;
   logic [NREGS-1:0] lock_d;
   logic [NREGS-1:0] clr_mask;
   logic [NREGS-1:0] set_mask;

   // Next lock state: clear on any write to the register, then let a new lock win.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      clr_mask = '0;
      set_mask = '0;
      for (int i = 0; i < NREGS; i++) begin
         clr_mask[i] = idx_hit(wr_en1, wr_sel1, i) || idx_hit(wr_en2, wr_sel2, i);
         set_mask[i] = idx_hit(lock_en, lock_sel, i);
      end
      lock_d = (lock_q & ~clr_mask) | set_mask;
   end

   // Lock register with asynchronous reset; the reset edge blocks any set or clear.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         lock_q <= '0;
      end else begin
         lock_q <= lock_d;
      end
   end

   // Busy flags look only at the registered locks; a clear landing this edge is not bypassed.
   assign busy1    = lock_q[GPR_sel1];
   assign busy2    = lock_q[GPR_sel2];
   assign lock_vec = lock_q;

endmodule : gpr_scoreboard

// File: rtl/gpr_file.sv
// 16-entry general-purpose register bank: two registered read ports with write-first
// bypass, two write ports (port 2 carries the multiply high half and wins collisions),
// and the pending-write scoreboard used by the control FSM to stall.
module gpr_file
   import gpr_file_pkg::*;
#(
   parameter int                DATA_W    = GPR_DATA_W,
   parameter int                NREGS     = GPR_NREGS,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  reg_idx_t          GPR_sel1,
   input  reg_idx_t          GPR_sel2,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              wr_en1,
   input  reg_idx_t          wr_sel1,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              wr_en2,
   input  reg_idx_t          wr_sel2,
   input  logic [DATA_W-1:0] wr_data2,
   input  logic              lock_en,
   input  reg_idx_t          lock_sel,
   output logic              busy1,
   output logic              busy2,
   output logic [NREGS-1:0]  lock_vec
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [DATA_W-1:0] rd_data1_q;
   logic [DATA_W-1:0] rd_data1_d;
   logic [DATA_W-1:0] rd_data2_q;
   logic [DATA_W-1:0] rd_data2_d;

   // Post-write register image: port 1 applied first, port 2 second so it wins a collision.
   always_comb begin
      regs_d = regs_q;
      if (wr_en1) begin
         regs_d[wr_sel1] = wr_data1;
      end
      if (wr_en2) begin
         regs_d[wr_sel2] = wr_data2;
      end
   end

   // Read capture from the post-write image, which gives write-first bypass for free.
   always_comb begin
      rd_data1_d = rd_data1_q;
      rd_data2_d = rd_data2_q;
      if (rd_en) begin
         rd_data1_d = regs_d[GPR_sel1];
         rd_data2_d = regs_d[GPR_sel2];
      end
   end

   // Register array and read-port flops; reset restores every entry to RESET_VAL.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the array is reset because software may read any register before writing it; this keeps it in flops rather than a RAM macro.
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= RESET_VAL;
         end
         rd_data1_q <= '0;
         rd_data2_q <= '0;
      end else begin
         regs_q     <= regs_d;
         rd_data1_q <= rd_data1_d;
         rd_data2_q <= rd_data2_d;
      end
   end

   assign rd_data1 = rd_data1_q;
   assign rd_data2 = rd_data2_q;

   gpr_scoreboard #(
      .NREGS (NREGS)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .wr_en1   (wr_en1),
      .wr_sel1  (wr_sel1),
      .wr_en2   (wr_en2),
      .wr_sel2  (wr_sel2),
      .lock_en  (lock_en),
      .lock_sel (lock_sel),
      .GPR_sel1 (GPR_sel1),
      .GPR_sel2 (GPR_sel2),
      .busy1    (busy1),
      .busy2    (busy2),
      .lock_vec (lock_vec)
   );

endmodule : gpr_file

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: a reference model predicts read data and lock bits as
// stimulus is driven, expectations are queued and popped after the clock edge.
module tb_gpr_file;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  GPR_sel1, GPR_sel2;
   logic        rd_en;
   logic [15:0] rd_data1, rd_data2;
   logic        wr_en1, wr_en2;
   logic [3:0]  wr_sel1, wr_sel2;
   logic [15:0] wr_data1, wr_data2;
   logic        lock_en;
   logic [3:0]  lock_sel;
   logic        busy1, busy2;
   logic [15:0] lock_vec;

   typedef struct {
      logic [15:0] d1;
      logic [15:0] d2;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] mdl [16];
   logic [15:0] hold1, hold2;
   logic [15:0] lk_m;
   int          tests = 0;
   int          fails = 0;

   gpr_file dut (
      .clk      (clk),
      .rst      (rst),
      .GPR_sel1 (GPR_sel1),
      .GPR_sel2 (GPR_sel2),
      .rd_en    (rd_en),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2),
      .wr_en1   (wr_en1),
      .wr_sel1  (wr_sel1),
      .wr_data1 (wr_data1),
      .wr_en2   (wr_en2),
      .wr_sel2  (wr_sel2),
      .wr_data2 (wr_data2),
      .lock_en  (lock_en),
      .lock_sel (lock_sel),
      .busy1    (busy1),
      .busy2    (busy2),
      .lock_vec (lock_vec)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr1(input logic [3:0] s, input logic [15:0] d);
      wr_en1 = 1'b1; wr_sel1 = s; wr_data1 = d;
   endtask

   task automatic wr2(input logic [3:0] s, input logic [15:0] d);
      wr_en2 = 1'b1; wr_sel2 = s; wr_data2 = d;
   endtask

   task automatic rd(input logic [3:0] s1, input logic [3:0] s2);
      rd_en = 1'b1; GPR_sel1 = s1; GPR_sel2 = s2;
   endtask

   task automatic lock(input logic [3:0] s);
      lock_en = 1'b1; lock_sel = s;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
      hold1 = 16'h0000;
      hold2 = 16'h0000;
      lk_m  = 16'h0000;
      exp_q.delete();
   endtask

   // Predict this edge, push the expectation, clock, then pop and compare.
   task automatic cycle(input string tag);
      exp_t        e;
      logic [15:0] nm [16];
      logic [15:0] clr, set;
      nm = mdl;
      if (wr_en1) nm[wr_sel1] = wr_data1;
      if (wr_en2) nm[wr_sel2] = wr_data2;
      if (rd_en) begin
         hold1 = nm[GPR_sel1];
         hold2 = nm[GPR_sel2];
      end
      e.d1 = hold1;
      e.d2 = hold2;
      exp_q.push_back(e);
      clr = 16'h0000;
      set = 16'h0000;
      if (wr_en1)  clr[wr_sel1]  = 1'b1;
      if (wr_en2)  clr[wr_sel2]  = 1'b1;
      if (lock_en) set[lock_sel] = 1'b1;
      lk_m = (lk_m & ~clr) | set;
      mdl  = nm;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, "/rd1"}, 32'(rd_data1), 32'(e.d1));
      check({tag, "/rd2"}, 32'(rd_data2), 32'(e.d2));
      check({tag, "/lock"}, 32'(lock_vec), 32'(lk_m));
      wr_en1  = 1'b0;
      wr_en2  = 1'b0;
      lock_en = 1'b0;
      rd_en   = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      GPR_sel1 = 4'd0; GPR_sel2 = 4'd0; rd_en = 1'b0;
      wr_en1 = 1'b0; wr_sel1 = 4'd0; wr_data1 = 16'h0000;
      wr_en2 = 1'b0; wr_sel2 = 4'd0; wr_data2 = 16'h0000;
      lock_en = 1'b0; lock_sel = 4'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset/rd1", 32'(rd_data1), 32'h0);
      check("reset/rd2", 32'(rd_data2), 32'h0);
      check("reset/lock", 32'(lock_vec), 32'h0);
      check("reset/busy1", 32'(busy1), 32'h0);
      rst = 1'b0;

      // Mid-stream reset: populate reg3 and a lock, then reset asynchronously.
      wr1(4'd3, 16'h1234);
      cycle("t1_wr");
      rd(4'd3, 4'd3); lock(4'd6);
      cycle("t1_rd");
      wr1(4'd3, 16'h5555); lock(4'd3);
      #2 rst = 1'b1;
      #1;
      check("t1_async/rd1", 32'(rd_data1), 32'h0);
      check("t1_async/rd2", 32'(rd_data2), 32'h0);
      check("t1_async/lock", 32'(lock_vec), 32'h0);
      @(posedge clk);
      #1;
      check("t1_rst_edge/lock", 32'(lock_vec), 32'h0);
      wr_en1 = 1'b0; lock_en = 1'b0;
      rst = 1'b0;
      model_reset();
      rd(4'd3, 4'd3);
      cycle("t1_after");

      // Basic write then read on both ports, then hold with rd_en low.
      wr1(4'd5, 16'hBEEF);
      cycle("t2_wr");
      rd(4'd5, 4'd5);
      cycle("t2_rd");
      wr1(4'd5, 16'h0001); GPR_sel1 = 4'd3;
      cycle("t2_hold1");
      cycle("t2_hold2");

      // Write-first bypass on port 2 while port 1 reads a different register.
      wr1(4'd7, 16'h00AA); rd(4'd5, 4'd7);
      cycle("t3_bypass");

      // Same-index collision: port 2 wins, also through the bypass.
      wr1(4'd2, 16'h1111); wr2(4'd2, 16'h2222); rd(4'd2, 4'd7);
      cycle("t4_collide");
      rd(4'd2, 4'd2);
      cycle("t4_readback");

      // Scoreboard lock, re-lock, clear by a port-2 write, busy without bypass.
      lock(4'd9);
      cycle("t5_lock");
      GPR_sel1 = 4'd9; GPR_sel2 = 4'd2;
      #1;
      check("t5/busy1_set", 32'(busy1), 32'h1);
      check("t5/busy2_clear", 32'(busy2), 32'h0);
      lock(4'd9);
      cycle("t5_relock");
      wr2(4'd9, 16'h9999);
      #1;
      check("t5/busy1_no_bypass", 32'(busy1), 32'h1);
      cycle("t5_clear");
      check("t5/busy1_cleared", 32'(busy1), 32'h0);

      // Lock and write on the same edge: data lands, lock stays set.
      wr1(4'd4, 16'h4444); lock(4'd4);
      cycle("t6_lock_write");
      GPR_sel2 = 4'd4;
      #1;
      check("t6/busy2", 32'(busy2), 32'h1);
      rd(4'd4, 4'd9);
      cycle("t6_read");

      // Clear one lock while setting another register's lock.
      wr1(4'd4, 16'h0404); lock(4'd12);
      cycle("t7_swap");
      rd(4'd4, 4'd12);
      cycle("t7_read");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_gpr_file
